// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_if
// Description : Bundle of handshake and bus signals between an instruction
//               source, the imm_encoder block and the instruction-memory
//               loader.
//   Input side  : in_valid/in_ready handshake, fmt, rd, rs1, rs2, funct3,
//                 funct7, imm, addr_clr
//   Output side : out_valid/out_ready handshake, out_ins, out_addr (AW bits),
//                 out_err, err_cnt
//   Modports    : master = source/consumer side, slave = encoder side
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_encoder_if #(
  parameter int unsigned AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          addr_clr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_ins;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [7:0]    err_cnt;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_ins, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, addr_clr, out_ready,
    output in_ready, out_valid, out_ins, out_addr, out_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Packs decoded instruction fields and a 32-bit immediate into
//               RV32I instruction words, tags each with a sequential byte
//               address and queues it in a 2-entry output FIFO.
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   bus       : imm_encoder_if.slave
//                 in_valid/in_ready + fields  -> accepted word
//                 out_valid/out_ready         -> FIFO head
//                 out_ins/out_addr/out_err    -> head contents
//                 err_cnt                     -> saturating error count
// Config      : IMM_RANGE_CHECK_EN - when defined, immediates are range
//               checked and out_err/err_cnt are live; otherwise both are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder #(
  parameter int unsigned   AW        = 16,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  localparam logic [2:0] c_FMT_IARITH = 3'd0;
  localparam logic [2:0] c_FMT_ISHIFT = 3'd1;
  localparam logic [2:0] c_FMT_LOAD   = 3'd2;
  localparam logic [2:0] c_FMT_S      = 3'd3;
  localparam logic [2:0] c_FMT_B      = 3'd4;
  localparam logic [2:0] c_FMT_U      = 3'd5;
  localparam logic [2:0] c_FMT_J      = 3'd6;

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [31:0]   c_NOP       = 32'h0000_0013;
  localparam logic [AW-1:0] c_ADDR_STEP = AW'(4);

  logic [31:0]   w_ins;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;

  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [31:0]   ins_q       [2];
  logic [AW-1:0] slot_addr_q [2];
  logic [AW-1:0] addr_q, addr_d;

  // Field packing; out-of-range immediates are simply truncated here.
  always_comb begin : c_pack
    w_ins = c_NOP;
    case (bus.fmt)
      c_FMT_IARITH: w_ins = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_OP_IMM};
      c_FMT_ISHIFT: w_ins = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, c_OP_IMM};
      c_FMT_LOAD:   w_ins = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_OP_LOAD};
      c_FMT_S:      w_ins = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], c_OP_STORE};
      c_FMT_B:      w_ins = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:1], bus.imm[11], c_OP_BRANCH};
      c_FMT_U:      w_ins = {bus.imm[31:12], bus.rd, c_OP_LUI};
      c_FMT_J:      w_ins = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, c_OP_JAL};
      default:      w_ins = c_NOP;
    endcase
  end

  // No bypass: a full FIFO refuses input even if the head pops this cycle.
  assign w_in_ready    = (count_q != 2'd2) && !rst;
  assign w_push        = bus.in_valid && w_in_ready;
  assign w_pop         = (count_q != 2'd0) && bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_ins   = ins_q[rd_ptr_q];
  assign bus.out_addr  = slot_addr_q[rd_ptr_q];

  always_comb begin : c_next
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Clear wins over increment; the word pushed this cycle still takes addr_q.
    if (bus.addr_clr) begin
      addr_d = BASE_ADDR;
    end else if (w_push) begin
      addr_d = addr_q + c_ADDR_STEP;
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin : s_fifo
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      for (int i = 0; i < 2; i++) begin
        ins_q[i]       <= '0;
        slot_addr_q[i] <= BASE_ADDR;
      end
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      if (w_push) begin
        ins_q[wr_ptr_q]       <= w_ins;
        slot_addr_q[wr_ptr_q] <= addr_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic       w_err;
  logic       w_sext11;
  logic       w_sext12;
  logic       w_sext20;
  logic       err_q [2];
  logic [7:0] err_cnt_q;

  // "All equal" over the upper bits means the value sign-extends from below.
  assign w_sext11 = (bus.imm[31:11] == {21{bus.imm[31]}});
  assign w_sext12 = (bus.imm[31:12] == {20{bus.imm[31]}});
  assign w_sext20 = (bus.imm[31:20] == {12{bus.imm[31]}});

  always_comb begin : c_range
    w_err = 1'b1;
    case (bus.fmt)
      c_FMT_IARITH,
      c_FMT_LOAD,
      c_FMT_S:      w_err = !w_sext11;
      c_FMT_ISHIFT: w_err = (bus.imm[31:5] != 27'd0);
      c_FMT_B:      w_err = !w_sext12 || bus.imm[0];
      c_FMT_U:      w_err = (bus.imm[11:0] != 12'd0);
      c_FMT_J:      w_err = !w_sext20 || bus.imm[0];
      default:      w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin : s_err
    if (rst) begin
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (w_push) begin
      err_q[wr_ptr_q] <= w_err;
      if (w_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.out_err = err_q[rd_ptr_q];
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.out_err = 1'b0;
  assign bus.err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Scoreboard bench for imm_encoder. Two instances: A with
//               BASE_ADDR=0x0000, B with BASE_ADDR=0xFFFC (address wrap and
//               clear). Expected words are queued on issue; a monitor per
//               instance pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  localparam int unsigned AW = 16;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic c_CHK = 1'b1;
`else
  localparam logic c_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] ins;
    logic [15:0] addr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_encoder_if #(.AW(AW)) ifa ();
  imm_encoder_if #(.AW(AW)) ifb ();

  imm_encoder #(.AW(AW), .BASE_ADDR(16'h0000)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  imm_encoder #(.AW(AW), .BASE_ADDR(16'hFFFC)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: compare every word the consumer takes against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_word", 32'(ifa.out_valid), 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_ins",  ifa.out_ins, ea.ins);
        chk("a_addr", 32'(ifa.out_addr), 32'(ea.addr));
        chk("a_err",  32'(ifa.out_err), 32'(ea.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", 32'(ifb.out_valid), 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_ins",  ifb.out_ins, eb.ins);
        chk("b_addr", 32'(ifb.out_addr), 32'(eb.addr));
        chk("b_err",  32'(ifb.out_err), 32'(eb.err));
      end
    end
  end

  // Issue one word to instance A (which=0) or B (which=1) and queue its expectation.
  task automatic push(input logic which, input logic [2:0] f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic clr,
                      input logic [31:0] ins, input logic [15:0] addr, input logic err);
    int n;
    if (!which) begin
      ifa.fmt = f; ifa.rd = rd; ifa.rs1 = rs1; ifa.rs2 = rs2; ifa.funct3 = f3;
      ifa.funct7 = f7; ifa.imm = imm; ifa.addr_clr = clr; ifa.in_valid = 1'b1;
      qa.push_back({ins, addr, err & c_CHK});
    end else begin
      ifb.fmt = f; ifb.rd = rd; ifb.rs1 = rs1; ifb.rs2 = rs2; ifb.funct3 = f3;
      ifb.funct7 = f7; ifb.imm = imm; ifb.addr_clr = clr; ifb.in_valid = 1'b1;
      qb.push_back({ins, addr, err & c_CHK});
    end
    n = 0;
    while (!(which ? ifb.in_ready : ifa.in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("push_timeout_in_ready", 32'(which ? ifb.in_ready : ifa.in_ready), 32'd1);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.addr_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.addr_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ifa.out_valid || ifb.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_a_left", 32'(qa.size()), 32'd0);
    chk("drain_b_left", 32'(qb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.addr_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.addr_clr = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready_low", 32'(ifa.in_ready), 32'd0);
    qa.delete();
    qb.delete();
    rst = 1'b0;
    #1;
    chk("rst_out_valid",  32'(ifa.out_valid), 32'd0);
    chk("rst_out_ins",    ifa.out_ins, 32'd0);
    chk("rst_out_addr_a", 32'(ifa.out_addr), 32'h0000);
    chk("rst_out_addr_b", 32'(ifb.out_addr), 32'hFFFC);
    chk("rst_out_err",    32'(ifa.out_err), 32'd0);
    chk("rst_err_cnt",    32'(ifa.err_cnt), 32'd0);
    chk("rst_in_ready",   32'(ifa.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.fmt = 3'd0; ifa.rd = 5'd0; ifa.rs1 = 5'd0; ifa.rs2 = 5'd0;
    ifa.funct3 = 3'd0; ifa.funct7 = 7'd0; ifa.imm = 32'd0; ifa.addr_clr = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.fmt = 3'd0; ifb.rd = 5'd0; ifb.rs1 = 5'd0; ifb.rs2 = 5'd0;
    ifb.funct3 = 3'd0; ifb.funct7 = 7'd0; ifb.imm = 32'd0; ifb.addr_clr = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // First word: latency of one cycle into an empty FIFO.
    push(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'h0000, 1'b0);
    chk("latency_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("latency_out_ins",   ifa.out_ins, 32'h0050_0093);
    ifa.out_ready = 1'b1;
    drain();

    // Back-to-back formats with the consumer always ready.
    do_reset();
    ifa.out_ready = 1'b1;
    push(1'b0, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          1'b0, 32'h0020_A423, 16'h0000, 1'b0);
    push(1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,  1'b0, 32'hFE00_0EE3, 16'h0004, 1'b0);
    push(1'b0, 3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  1'b0, 32'h1234_52B7, 16'h0008, 1'b0);
    push(1'b0, 3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,  1'b0, 32'h0010_00EF, 16'h000C, 1'b0);
    push(1'b0, 3'd1, 5'd2, 5'd3, 5'd0, 3'd1, 7'h20, 32'd7,         1'b0, 32'h4071_9113, 16'h0010, 1'b0);
    push(1'b0, 3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8,  1'b0, 32'hFF81_2203, 16'h0014, 1'b0);
    drain();
    chk("err_cnt_clean", 32'(ifa.err_cnt), 32'd0);

    // Range violations: word still emitted, truncated.
    push(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h8000_0093, 16'h0018, 1'b1);
    drain();
    chk("err_cnt_after_2048", 32'(ifa.err_cnt), 32'(c_CHK));
    push(1'b0, 3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 7'd0, 32'd0, 1'b0, 32'h0000_0013, 16'h001C, 1'b1);
    push(1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0000_0163, 16'h0020, 1'b1);
    drain();
    chk("err_cnt_after_3", 32'(ifa.err_cnt), c_CHK ? 32'd3 : 32'd0);

    // Back-pressure: FIFO fills at 2, head holds, no bypass on pop.
    do_reset();
    ifa.out_ready = 1'b0;
    push(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'h0000, 1'b0);
    push(1'b0, 3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0113, 16'h0004, 1'b0);
    chk("full_in_ready", 32'(ifa.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("stall_head_ins",  ifa.out_ins, 32'h0050_0093);
    chk("stall_head_addr", 32'(ifa.out_addr), 32'h0000);
    ifa.out_ready = 1'b1;
    #1;
    chk("no_bypass_in_ready", 32'(ifa.in_ready), 32'd0);
    push(1'b0, 3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0193, 16'h0008, 1'b0);
    drain();

    // Reset mid-operation discards queued words.
    ifa.out_ready = 1'b0;
    push(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'h000C, 1'b0);
    push(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'h0010, 1'b0);
    do_reset();

    // err_cnt saturation: 256 illegal words.
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push(1'b0, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0000_0013, 16'(i * 4), 1'b1);
    end
    drain();
    chk("err_cnt_saturated", 32'(ifa.err_cnt), c_CHK ? 32'd255 : 32'd0);

    // Instance B: wrap from 0xFFFC, then clear coinciding with a push.
    ifb.out_ready = 1'b1;
    push(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'hFFFC, 1'b0);
    push(1'b1, 3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0113, 16'h0000, 1'b0);
    push(1'b1, 3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1, 32'h0020_0193, 16'h0004, 1'b0);
    push(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 16'hFFFC, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
